psum_acc_sequencer: RTL

//  Hardware sequencer for the accumulation phase of the core.

---
 rtl/psum_acc_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/psum_acc_sequencer.sv
// Accumulation-phase sequencer: walks every output pixel, reads its K*K kij-shifted
// psum words, drives SFP clear/accumulate/ReLU and hands each result over valid/ready.
module psum_acc_sequencer #(
    parameter int IN_W       = 10,
    parameter int OUT_W      = 8,
    parameter int K          = 3,
    parameter int KIJ_STRIDE = 128,
    parameter int ADDR_BW    = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               relu_en,
    output logic               CEN_pmem,
    output logic               WEN_pmem,
    output logic [ADDR_BW-1:0] A_pmem,
    output logic               sfp_clr,
    output logic               acc,
    output logic               relu,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         out_idx,
    output logic               busy,
    output logic               done
);

    localparam int RW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    localparam logic [RW-1:0]      OUT_LAST = RW'(OUT_W - 1);
    localparam logic [KW-1:0]      K_LAST   = KW'(K - 1);
    // Address deltas between consecutive reads and consecutive pixels.
    localparam logic [ADDR_BW-1:0] STEP_KJ  = ADDR_BW'(KIJ_STRIDE + 1);
    localparam logic [ADDR_BW-1:0] STEP_KI  = ADDR_BW'(KIJ_STRIDE + IN_W - (K - 1));
    localparam logic [ADDR_BW-1:0] STEP_ROW = ADDR_BW'(IN_W - (OUT_W - 1));

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_RD, S_DRAIN, S_RELU, S_EMIT
    } state_t;

    state_t             state, state_d;
    logic [RW-1:0]      orow, orow_d, ocol, ocol_d;
    logic [KW-1:0]      ki, ki_d, kj, kj_d;
    logic [ADDR_BW-1:0] base, base_d, addr_d;
    logic               relu_l, relu_l_d;
    logic               cen_d, clr_d, acc_d, relu_d, valid_d, busy_d, done_d;
    logic [5:0]         idx_d;

    assign WEN_pmem = 1'b1;

    // NOTE: every output is assigned a default before the case statement so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state;
        orow_d   = orow;
        ocol_d   = ocol;
        ki_d     = ki;
        kj_d     = kj;
        base_d   = base;
        relu_l_d = relu_l;
        addr_d   = A_pmem;
        cen_d    = CEN_pmem;
        idx_d    = out_idx;
        busy_d   = busy;
        clr_d    = 1'b0;
        acc_d    = 1'b0;
        relu_d   = 1'b0;
        valid_d  = 1'b0;
        done_d   = 1'b0;

        unique case (state)
            S_IDLE: if (start) begin
                state_d  = S_CLR;
                busy_d   = 1'b1;
                clr_d    = 1'b1;
                orow_d   = '0;
                ocol_d   = '0;
                base_d   = '0;
                idx_d    = '0;
                relu_l_d = relu_en;
            end
            S_CLR: begin
                state_d = S_RD;
                cen_d   = 1'b0;
                addr_d  = base;
                ki_d    = '0;
                kj_d    = '0;
            end
            S_RD: begin
                // Read data lands one cycle after its address, so acc trails by one.
                acc_d = 1'b1;
                if (kj == K_LAST && ki == K_LAST) begin
                    state_d = S_DRAIN;
                    cen_d   = 1'b1;
                end else if (kj == K_LAST) begin
                    kj_d   = '0;
                    ki_d   = ki + 1'b1;
                    addr_d = A_pmem + STEP_KI;
                end else begin
                    kj_d   = kj + 1'b1;
                    addr_d = A_pmem + STEP_KJ;
                end
            end
            S_DRAIN: begin
                state_d = S_RELU;
                relu_d  = relu_l;
            end
            S_RELU: begin
                state_d = S_EMIT;
                valid_d = 1'b1;
            end
            S_EMIT: begin
                if (!out_ready) begin
                    valid_d = 1'b1;
                end else if (orow == OUT_LAST && ocol == OUT_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    idx_d   = '0;
                end else begin
                    state_d = S_CLR;
                    clr_d   = 1'b1;
                    idx_d   = out_idx + 1'b1;
                    if (ocol == OUT_LAST) begin
                        ocol_d = '0;
                        orow_d = orow + 1'b1;
                        base_d = base + STEP_ROW;
                    end else begin
                        ocol_d = ocol + 1'b1;
                        base_d = base + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: reset is sampled on the clock edge here; it is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            orow      <= '0;
            ocol      <= '0;
            ki        <= '0;
            kj        <= '0;
            base      <= '0;
            relu_l    <= 1'b0;
            A_pmem    <= '0;
            CEN_pmem  <= 1'b1;
            sfp_clr   <= 1'b0;
            acc       <= 1'b0;
            relu      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            orow      <= orow_d;
            ocol      <= ocol_d;
            ki        <= ki_d;
            kj        <= kj_d;
            base      <= base_d;
            relu_l    <= relu_l_d;
            A_pmem    <= addr_d;
            CEN_pmem  <= cen_d;
            sfp_clr   <= clr_d;
            acc       <= acc_d;
            relu      <= relu_d;
            out_valid <= valid_d;
            out_idx   <= idx_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule
